uart_rx_fsm: RTL and testbench

//  Frame-sequencing controller for the UART receiver, in the RX clock domain.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_fsm_if.sv | 53 +++++
 rtl/uart_rx_fsm.sv | 156 +++++++++++++++
 tb/tb_uart_rx_fsm.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int START_IDX  = 0;
    localparam int PAR_IDX    = DEF_DATA_W + 1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_ERR_CHK = 3'd5,
        S_DONE    = 3'd6
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the frame sequencer and its counters/checkers.
// UART_RX_ERR_STATUS_EN adds err_clr / err_status.
interface uart_rx_fsm_if #(
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;
    logic                  edge_bit_cnt_en;
    logic                  dat_samp_en;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  data_valid;
`ifdef UART_RX_ERR_STATUS_EN
    logic                  err_clr;
    logic [2:0]            err_status;

    modport master (
        output RX_IN, PAR_EN, prescale, edge_cnt, bit_cnt,
        output strt_glitch, par_err, stp_err, err_clr,
        input  edge_bit_cnt_en, dat_samp_en, deser_en,
        input  strt_chk_en, par_chk_en, stp_chk_en, data_valid, err_status
    );

    modport slave (
        input  RX_IN, PAR_EN, prescale, edge_cnt, bit_cnt,
        input  strt_glitch, par_err, stp_err, err_clr,
        output edge_bit_cnt_en, dat_samp_en, deser_en,
        output strt_chk_en, par_chk_en, stp_chk_en, data_valid, err_status
    );
`else
    modport master (
        output RX_IN, PAR_EN, prescale, edge_cnt, bit_cnt,
        output strt_glitch, par_err, stp_err,
        input  edge_bit_cnt_en, dat_samp_en, deser_en,
        input  strt_chk_en, par_chk_en, stp_chk_en, data_valid
    );

    modport slave (
        input  RX_IN, PAR_EN, prescale, edge_cnt, bit_cnt,
        input  strt_glitch, par_err, stp_err,
        output edge_bit_cnt_en, dat_samp_en, deser_en,
        output strt_chk_en, par_chk_en, stp_chk_en, data_valid
    );
`endif
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: START/DATA/PARITY/STOP walk with registered enables.
// Optional sticky error history under UART_RX_ERR_STATUS_EN.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic         CLK,
    input  logic         RST,
    uart_rx_fsm_if.slave bus
);

    rx_state_e             r_state;
    rx_state_e             w_next;
    logic                  r_par_en;
    logic                  w_par_en;
    logic [PRESCALE_W-1:0] w_last_edge;
    logic                  w_last;

    logic w_cnt_en, w_samp_en, w_deser_en, w_strt_chk_en;
    logic w_par_chk_en, w_stp_chk_en, w_data_valid;
    logic r_cnt_en, r_samp_en, r_deser_en, r_strt_chk_en;
    logic r_par_chk_en, r_stp_chk_en, r_data_valid;

    assign w_last_edge = bus.prescale - PRESCALE_W'(1);
    assign w_last      = (bus.edge_cnt == w_last_edge);

    always_comb begin
        w_next        = r_state;
        w_par_en      = r_par_en;
        w_cnt_en      = 1'b0;
        w_samp_en     = 1'b0;
        w_deser_en    = 1'b0;
        w_strt_chk_en = 1'b0;
        w_par_chk_en  = 1'b0;
        w_stp_chk_en  = 1'b0;
        w_data_valid  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!bus.RX_IN) begin
                    w_next   = S_START;
                    w_par_en = bus.PAR_EN;
                end
            end
            S_START: begin
                if (w_last) w_next = bus.strt_glitch ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_last) begin
                    w_deser_en = 1'b1;
                    if (bus.bit_cnt == 4'(DATA_W)) w_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_last) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_last) w_next = S_ERR_CHK;
            end
            S_ERR_CHK: w_next = S_DONE;
            S_DONE: begin
                // Checker results latched during ERR_CHK are valid here.
                w_data_valid = !bus.stp_err && !(r_par_en && bus.par_err);
                if (!bus.RX_IN) begin
                    w_next   = S_START;
                    w_par_en = bus.PAR_EN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase

        // Enables are decoded from the next state so they register in step with it.
        case (w_next)
            S_START: begin
                w_cnt_en      = 1'b1;
                w_samp_en     = 1'b1;
                w_strt_chk_en = 1'b1;
            end
            S_DATA: begin
                w_cnt_en  = 1'b1;
                w_samp_en = 1'b1;
            end
            S_PARITY: begin
                w_cnt_en     = 1'b1;
                w_samp_en    = 1'b1;
                w_par_chk_en = 1'b1;
            end
            S_STOP: begin
                w_cnt_en     = 1'b1;
                w_samp_en    = 1'b1;
                w_stp_chk_en = 1'b1;
            end
            S_ERR_CHK: begin
                w_cnt_en     = 1'b1;
                w_stp_chk_en = 1'b1;
                w_par_chk_en = r_par_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= S_IDLE;
            r_par_en      <= 1'b0;
            r_cnt_en      <= 1'b0;
            r_samp_en     <= 1'b0;
            r_deser_en    <= 1'b0;
            r_strt_chk_en <= 1'b0;
            r_par_chk_en  <= 1'b0;
            r_stp_chk_en  <= 1'b0;
            r_data_valid  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_par_en      <= w_par_en;
            r_cnt_en      <= w_cnt_en;
            r_samp_en     <= w_samp_en;
            r_deser_en    <= w_deser_en;
            r_strt_chk_en <= w_strt_chk_en;
            r_par_chk_en  <= w_par_chk_en;
            r_stp_chk_en  <= w_stp_chk_en;
            r_data_valid  <= w_data_valid;
        end
    end

    assign bus.edge_bit_cnt_en = r_cnt_en;
    assign bus.dat_samp_en     = r_samp_en;
    assign bus.deser_en        = r_deser_en;
    assign bus.strt_chk_en     = r_strt_chk_en;
    assign bus.par_chk_en      = r_par_chk_en;
    assign bus.stp_chk_en      = r_stp_chk_en;
    assign bus.data_valid      = r_data_valid;

`ifdef UART_RX_ERR_STATUS_EN
    logic       w_glitch_evt, w_par_evt, w_stp_evt;
    logic [2:0] r_err_status;

    assign w_glitch_evt = (r_state == S_START) && w_last && bus.strt_glitch;
    assign w_par_evt    = (r_state == S_DONE) && r_par_en && bus.par_err;
    assign w_stp_evt    = (r_state == S_DONE) && bus.stp_err;

    // A new error in the clearing cycle survives the clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_err_status <= 3'b000;
        else      r_err_status <= (bus.err_clr ? 3'b000 : r_err_status)
                                  | {w_glitch_evt, w_par_evt, w_stp_evt};
    end

    assign bus.err_status = r_err_status;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the external counters/sampler/deserializer and
// checks frame outcomes against a frame-level reference model.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    localparam int DW = 8;

    typedef struct {
        logic [7:0] data;
        int         p;
        bit         par_en;
        bit         par_bad;
        bit         par_noise;
        bit         stop_bit;
        bit         glitch;
        bit         flip;
        int         exp_deser;
        bit         exp_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fsm_if #(.PRESCALE_W(6)) bus ();
    uart_rx_fsm #(.DATA_W(DW), .PRESCALE_W(6)) dut (.CLK(clk), .RST(rst_n), .bus(bus));

    // External edge/bit counter
    logic [5:0] env_edge;
    logic [3:0] env_bit;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !bus.edge_bit_cnt_en) begin
            env_edge <= '0;
            env_bit  <= '0;
        end else if (env_edge == bus.prescale - 6'd1) begin
            env_edge <= '0;
            env_bit  <= env_bit + 4'd1;
        end else begin
            env_edge <= env_edge + 6'd1;
        end
    end
    assign bus.edge_cnt = env_edge;
    assign bus.bit_cnt  = env_bit;

    // Centre sampler, deserializer and output pulse counters
    logic       samp;
    logic [7:0] shreg;
    logic [7:0] got [0:63];
    int n_deser, n_valid, n_strt, n_par, n_stp, n_off;
    always @(negedge clk) begin
        if (bus.dat_samp_en && env_edge == (bus.prescale >> 1)) samp <= bus.RX_IN;
        if (bus.deser_en) begin
            shreg   <= {samp, shreg[7:1]};
            n_deser <= n_deser + 1;
        end
        if (bus.data_valid) begin
            got[n_valid[5:0]] <= shreg;
            n_valid <= n_valid + 1;
        end
        if (bus.strt_chk_en) n_strt <= n_strt + 1;
        if (bus.par_chk_en)  n_par  <= n_par + 1;
        if (bus.stp_chk_en)  n_stp  <= n_stp + 1;
        if (!bus.edge_bit_cnt_en) n_off <= n_off + 1;
    end

    int checks = 0;
    int errors = 0;
`ifdef UART_RX_ERR_STATUS_EN
    logic [2:0] exp_status = 3'b000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".cnt_en"},   bus.edge_bit_cnt_en, 0);
        check({tag, ".samp_en"},  bus.dat_samp_en, 0);
        check({tag, ".deser_en"}, bus.deser_en, 0);
        check({tag, ".strt_chk"}, bus.strt_chk_en, 0);
        check({tag, ".par_chk"},  bus.par_chk_en, 0);
        check({tag, ".stp_chk"},  bus.stp_chk_en, 0);
        check({tag, ".valid"},    bus.data_valid, 0);
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        m.exp_deser = v.glitch ? 0 : DW;
        m.exp_valid = !v.glitch && v.stop_bit && !(v.par_en && v.par_bad);
        return m;
    endfunction

    task automatic drive_bit(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit par_en,
                              input bit par_bad, input bit stop_bit, input bit flip);
        bus.PAR_EN = par_en;
        bus.RX_IN  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (flip) bus.PAR_EN = ~par_en;
        repeat (p - 2) @(posedge clk);
        #1;
        for (int i = 0; i < DW; i++) drive_bit(d[i], p);
        if (par_en) drive_bit(par_bad ? ~(^d) : ^d, p);
        bus.PAR_EN = par_en;
        drive_bit(stop_bit, p);
        bus.RX_IN = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int d0 = n_deser;
        int v0 = n_valid;
        int s0 = n_strt;
        int q0 = n_par;
        int t0 = n_stp;
        bus.prescale    = 6'(v.p);
        bus.strt_glitch = v.glitch;
        bus.par_err     = v.par_en ? v.par_bad : v.par_noise;
        bus.stp_err     = !v.stop_bit;
        if (v.glitch) begin
            bus.RX_IN = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            bus.RX_IN = 1'b1;
        end else begin
            send_frame(v.data, v.p, v.par_en, v.par_bad, v.stop_bit, v.flip);
        end
        repeat (v.p + 8) @(posedge clk);
        #1;
        check({tag, ".deser_cnt"}, n_deser - d0, v.exp_deser);
        check({tag, ".valid_cnt"}, n_valid - v0, v.exp_valid);
        if (v.exp_valid) check({tag, ".byte"}, got[v0[5:0]], v.data);
        check({tag, ".strt_cyc"}, n_strt - s0, v.p);
        check({tag, ".par_cyc"},  n_par - q0, (!v.glitch && v.par_en) ? v.p + 1 : 0);
        check({tag, ".stp_cyc"},  n_stp - t0, v.glitch ? 0 : v.p + 1);
        check({tag, ".idle"},     bus.edge_bit_cnt_en, 0);
`ifdef UART_RX_ERR_STATUS_EN
        exp_status = exp_status | {v.glitch, !v.glitch && v.par_en && v.par_bad,
                                   !v.glitch && !v.stop_bit};
        check({tag, ".err_status"}, bus.err_status, exp_status);
`endif
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        vec_t v;
        int   v0, d0, o0;
        bus.RX_IN = 1'b1;
        bus.PAR_EN = 1'b0;
        bus.prescale = 6'd8;
        bus.strt_glitch = 1'b0;
        bus.par_err = 1'b0;
        bus.stp_err = 1'b0;
`ifdef UART_RX_ERR_STATUS_EN
        bus.err_clr = 1'b0;
`endif
        //          data   p   pen bad nse stp gl flp  deser valid
        tbl[0] = '{8'hA5,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b1};
        tbl[1] = '{8'h3C,  8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b0};
        tbl[2] = '{8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        tbl[3] = '{8'h7E, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0};
        tbl[4] = '{8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8, 1'b1};
        tbl[5] = '{8'h00, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
`ifdef UART_RX_ERR_STATUS_EN
        check("reset.err_status", bus.err_status, 3'b000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

`ifdef UART_RX_ERR_STATUS_EN
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        exp_status = 3'b000;
        check("err_clr", bus.err_status, exp_status);
`endif

        // Back-to-back frames: DONE must go straight to START
        bus.prescale = 6'd16;
        v0 = n_valid;
        d0 = n_deser;
        o0 = n_off;
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b.off_cycles", n_off - o0, 2);
        repeat (24) @(posedge clk);
        #1;
        check("b2b.valid_cnt", n_valid - v0, 2);
        check("b2b.deser_cnt", n_deser - d0, 16);
        check("b2b.byte0", got[v0[5:0]], 8'h55);
        check("b2b.byte1", got[6'(v0 + 1)], 8'hFF);

        // Reset in the middle of the data bits
        bus.prescale = 6'd8;
        v0 = n_valid;
        bus.PAR_EN = 1'b0;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 8);
        bus.RX_IN = 1'b0;
        for (int k = 0; k < 200 && !(env_bit == 4'd4 && env_edge == 6'd2); k++) @(posedge clk);
        #1;
        check("rst.reach_bit4", env_bit, 4);
        check("rst.busy_before", bus.edge_bit_cnt_en, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.RX_IN = 1'b1;
`ifdef UART_RX_ERR_STATUS_EN
        exp_status = 3'b000;
`endif
        repeat (20) @(posedge clk);
        #1;
        check("rst.no_valid", n_valid - v0, 0);
        v = '{8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        run_vec(model(v), "after_rst");

        // Randomized frames against the frame-level model
        for (int r = 0; r < 20; r++) begin
            case ($urandom_range(0, 2))
                0:       v.p = PRESCALE_8;
                1:       v.p = PRESCALE_16;
                default: v.p = PRESCALE_32;
            endcase
            v.data      = 8'($urandom);
            v.par_en    = 1'($urandom_range(0, 1));
            v.par_bad   = ($urandom_range(0, 3) == 0);
            v.par_noise = 1'($urandom_range(0, 1));
            v.stop_bit  = ($urandom_range(0, 5) != 0);
            v.glitch    = ($urandom_range(0, 7) == 0);
            v.flip      = 1'($urandom_range(0, 1));
            run_vec(model(v), $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
